// File: rtl/ofm_writeback.sv
// OFM writeback: captures one pixel of per-PE results into a small FIFO and streams it
// to the OFM BRAM as 32-bit words. Define OFM_RELU_EN to clamp negative bytes at capture.
module ofm_writeback #(
    parameter int NUM_PE     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_PIXELS = 3136,
    parameter int ADDR_W     = 20,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NUM_PE-1:0]     valid,
    input  logic [NUM_PE*8-1:0]   ofm_in,
    input  logic                  wr_ready,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  valid_err
);
    localparam int WPP   = NUM_PE / 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int K_W   = (WPP > 1) ? $clog2(WPP) : 1;
    // Room for the few pixels that can still drain from the FIFO after done.
    localparam int PIX_W = $clog2(NUM_PIXELS + FIFO_DEPTH + 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [NUM_PE*8-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic [K_W-1:0]       k;
    logic [PIX_W-1:0]     pix_cnt;
    logic [NUM_PE*8-1:0]  cap_data;
    logic [NUM_PE*8-1:0]  head;
    logic [31:0]          word;
    logic                 empty, full, xfer, last_word, pop, capture, push, more;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = ((wr_ptr ^ rd_ptr) == {1'b1, {PTR_W{1'b0}}});
    assign wr_en     = (state_q == SEND);
    assign xfer      = wr_en && wr_ready;
    assign last_word = (k == K_W'(WPP - 1));
    assign pop       = xfer && last_word;
    assign capture   = (&valid) && !done && !start;
    assign push      = capture && (!full || pop);
    assign more      = ((rd_ptr + (PTR_W+1)'(1)) != wr_ptr) || push;
    assign busy      = !empty || wr_en;
    assign wr_addr   = wr_en ? (ADDR_W'(BASE_ADDR) + ADDR_W'(pix_cnt) * ADDR_W'(WPP) + ADDR_W'(k))
                             : '0;

    always_comb begin
        cap_data = ofm_in;
`ifdef OFM_RELU_EN
        for (int n = 0; n < NUM_PE; n++) begin
            if (ofm_in[8*n+7]) cap_data[8*n +: 8] = 8'h00;
        end
`endif
    end

    // Channel 4k lands in the top byte of word k.
    always_comb begin
        head    = mem[rd_ptr[PTR_W-1:0]];
        word    = head[32*k +: 32];
        wr_data = '0;
        if (wr_en) begin
            for (int j = 0; j < 4; j++) wr_data[31-8*j -: 8] = word[8*j +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!empty || push) state_d = SEND;
            SEND: if (pop && !more)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= cap_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            k         <= '0;
            pix_cnt   <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            valid_err <= 1'b0;
        end else if (start) begin
            state_q   <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            k         <= '0;
            pix_cnt   <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            valid_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + (PTR_W+1)'(1);
                pix_cnt <= pix_cnt + PIX_W'(1);
                k       <= '0;
                if (pix_cnt == PIX_W'(NUM_PIXELS - 1)) done <= 1'b1;
            end else if (xfer) begin
                k <= k + K_W'(1);
            end
            if (capture && full && !pop) overflow <= 1'b1;
            if ((|valid) && !(&valid))   valid_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofm_writeback.sv
// Randomised and directed bench for ofm_writeback against a word-queue reference model.
`timescale 1ns/1ps
module tb_ofm_writeback;
    localparam int NUM_PE     = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_PIXELS = 3;
    localparam int ADDR_W     = 20;
    localparam int BASE_ADDR  = 0;
    localparam int WPP        = NUM_PE / 4;
    localparam logic [NUM_PE-1:0] ALL = '1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [NUM_PE-1:0]    valid;
    logic [NUM_PE*8-1:0]  ofm_in;
    logic                 wr_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [31:0]          wr_data;
    logic                 busy, done, overflow, valid_err;

    ofm_writeback #(
        .NUM_PE(NUM_PE), .FIFO_DEPTH(FIFO_DEPTH), .NUM_PIXELS(NUM_PIXELS),
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .ofm_in(ofm_in),
        .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .overflow(overflow), .valid_err(valid_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words in order, words written this layer, sticky flags.
    logic [31:0] exp_q[$];
    int          written;
    logic        m_done, m_ovf, m_verr;
    // Handshakes observed on the DUT port.
    logic [31:0] log_data[$];
    int          log_addr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] store_byte(input logic [7:0] b);
`ifdef OFM_RELU_EN
        return ($signed(b) < 0) ? 8'h00 : b;
`else
        return b;
`endif
    endfunction

    function automatic logic [31:0] pix_word(input logic [NUM_PE*8-1:0] px, input int kk);
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) w = {w[23:0], store_byte(px[8*(4*kk+j) +: 8])};
        return w;
    endfunction

    function automatic logic [NUM_PE*8-1:0] rand_px();
        logic [NUM_PE*8-1:0] p;
        for (int i = 0; i < WPP; i++) p[32*i +: 32] = $urandom();
        return p;
    endfunction

    function automatic logic [NUM_PE*8-1:0] inc_px();
        logic [NUM_PE*8-1:0] p;
        for (int n = 0; n < NUM_PE; n++) p[8*n +: 8] = 8'(n);
        return p;
    endfunction

    // One clock: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic s, input logic [NUM_PE-1:0] v,
                        input logic [NUM_PE*8-1:0] d, input logic r);
        int  sz;
        logic full, pop;
        start = s; valid = v; ofm_in = d; wr_ready = r;
        sz = exp_q.size();
        check("wr_en", wr_en, sz > 0);
        if (sz > 0) begin
            check("wr_addr", wr_addr, (BASE_ADDR + written) % (1 << ADDR_W));
            check("wr_data", wr_data, exp_q[0]);
        end
        check("busy", busy, sz > 0);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
        check("valid_err", valid_err, m_verr);
        if (wr_en && r) begin
            log_data.push_back(wr_data);
            log_addr.push_back(int'(wr_addr));
        end
        if (s) begin
            exp_q.delete();
            written = 0;
            m_done = 0; m_ovf = 0; m_verr = 0;
        end else begin
            pop  = (sz > 0) && r && (sz % WPP == 1);
            full = ((sz + WPP - 1) / WPP) == FIFO_DEPTH;
            if (v == ALL && !m_done) begin
                if (!full || pop) for (int kk = 0; kk < WPP; kk++) exp_q.push_back(pix_word(d, kk));
                else m_ovf = 1;
            end
            if (v != '0 && v != ALL) m_verr = 1;
            if (sz > 0 && r) begin
                void'(exp_q.pop_front());
                written++;
                if (written == NUM_PIXELS * WPP) m_done = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) step(1'b0, '0, '0, r);
    endtask

    task automatic new_layer();
        step(1'b1, '0, '0, 1'b1);
        log_data.delete();
        log_addr.delete();
    endtask

    logic [31:0] t1_exp [4];
    logic [NUM_PE*8-1:0] px;

    initial begin
        t1_exp = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        reset = 1'b0; start = 1'b0; valid = '0; ofm_in = '0; wr_ready = 1'b0;
        exp_q.delete(); written = 0; m_done = 0; m_ovf = 0; m_verr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_valid_err", valid_err, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel, ready tied high.
        new_layer();
        step(1'b0, ALL, inc_px(), 1'b1);
        idle(6, 1'b1);
        check("t1_count", log_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_data.size()) begin
                check("t1_data", log_data[i], t1_exp[i]);
                check("t1_addr", log_addr[i], BASE_ADDR + i);
            end
        end
        check("t1_busy", busy, 0);

        // Stall mid-pixel.
        new_layer();
        step(1'b0, ALL, inc_px(), 1'b1);
        step(1'b0, '0, '0, 1'b1);
        idle(5, 1'b0);
        idle(6, 1'b1);
        check("t2_count", log_data.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_data.size()) check("t2_data", log_data[i], t1_exp[i]);

        // Overflow with five captures while stalled.
        new_layer();
        repeat (5) step(1'b0, ALL, rand_px(), 1'b0);
        check("t3_overflow", overflow, 1);
        idle(24, 1'b1);
        check("t3_words", log_data.size(), 16);

        // Full FIFO, capture coincides with pop.
        new_layer();
        repeat (4) step(1'b0, ALL, rand_px(), 1'b0);
        idle(3, 1'b1);
        step(1'b0, ALL, rand_px(), 1'b1);
        idle(25, 1'b1);
        check("t3b_overflow", overflow, 0);
        check("t3b_words", log_data.size(), 20);

        // End of layer.
        new_layer();
        repeat (3) step(1'b0, ALL, rand_px(), 1'b1);
        idle(15, 1'b1);
        check("t4_done", done, 1);
        check("t4_words", log_data.size(), 12);
        if (log_addr.size() > 0) check("t4_last_addr", log_addr[log_addr.size()-1], BASE_ADDR + 11);
        step(1'b0, ALL, rand_px(), 1'b1);
        idle(3, 1'b1);
        check("t4_ignored_busy", busy, 0);
        check("t4_ignored_words", log_data.size(), 12);
        new_layer();
        check("t4_done_clr", done, 0);

        // Partial valid.
        new_layer();
        step(1'b0, 16'h7FFF, rand_px(), 1'b1);
        check("t5_valid_err", valid_err, 1);
        check("t5_busy", busy, 0);
        idle(2, 1'b1);

        // Start mid-send.
        new_layer();
        step(1'b0, ALL, rand_px(), 1'b1);
        idle(2, 1'b1);
        step(1'b1, '0, '0, 1'b1);
        check("t6_wr_en", wr_en, 0);
        log_data.delete(); log_addr.delete();
        step(1'b0, ALL, rand_px(), 1'b1);
        idle(6, 1'b1);
        check("t6_words", log_data.size(), 4);
        if (log_addr.size() > 0) check("t6_addr", log_addr[0], BASE_ADDR);

        // Negative bytes.
        new_layer();
        px = '0;
        px[7:0] = 8'h85; px[15:8] = 8'h7F; px[23:16] = 8'h85;
        step(1'b0, ALL, px, 1'b1);
        idle(6, 1'b1);
`ifdef OFM_RELU_EN
        if (log_data.size() > 0) check("t7_relu", log_data[0], 32'h007F0000);
`else
        if (log_data.size() > 0) check("t7_raw", log_data[0], 32'h857F8500);
`endif

        // Random layers.
        for (int layer = 0; layer < 25; layer++) begin
            new_layer();
            for (int c = 0; c < 40; c++) begin
                int sel;
                logic [NUM_PE-1:0] v;
                sel = $urandom_range(0, 9);
                if (sel < 6)      v = ALL;
                else if (sel < 9) v = '0;
                else              v = NUM_PE'($urandom_range(1, (1 << NUM_PE) - 2));
                step($urandom_range(0, 39) == 0, v, rand_px(), $urandom_range(0, 9) < 7);
            end
            idle(30, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ofm_writeback.md
Name: ofm_writeback

Overview:
- Downstream stage of the 16-PE convolution core.
- Captures the per-PE 8-bit OFM results for one output pixel whenever all PE valid bits are high, and buffers them in a small pixel FIFO.
- Serialises each pixel into 32-bit words, 4 channels per word, and writes them to the OFM BRAM through a ready/enable write port with sequential address generation.
- Flags end of layer and error conditions to the layer controller.

Parameters:
- NUM_PE, 16, number of PE channels per pixel; must be a multiple of 4.
- FIFO_DEPTH, 4, pixel entries buffered; power of 2, minimum 2.
- NUM_PIXELS, 3136, output pixels per layer (56x56).
- ADDR_W, 20, write address width.
- BASE_ADDR, 0, word address of pixel 0 channel 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; clears counters, FIFO and flags for a new layer
- valid  in  NUM_PE  per-PE result valid from the conv core
- ofm_in  in  NUM_PE*8  packed OFM bytes; PE n occupies bits [8n+7:8n]
- wr_ready  in  1  BRAM side can accept a word this cycle
- wr_en  out  1  write request
- wr_addr  out  ADDR_W  word address
- wr_data  out  32  packed word
- busy  out  1  FIFO non-empty or a word is pending
- done  out  1  all NUM_PIXELS*NUM_PE/4 words written; sticky
- overflow  out  1  sticky; a pixel was dropped because the FIFO was full
- valid_err  out  1  sticky; valid was nonzero but not all ones

Behaviour:
- Reset (async, reset=0): all outputs 0, FIFO empty, pixel/word counters 0.
- Capture:
  - Occurs on a posedge where valid is all ones, done=0 and start=0.
  - The full ofm_in vector is pushed as one FIFO entry.
  - A valid that is nonzero but not all ones is ignored and sets valid_err.
- Word packing:
  - Word k of a pixel = {ch4k, ch4k+1, ch4k+2, ch4k+3}; ch4k sits in bits [31:24].
  - This is the same MSB-first order used for IFM/weight loading.
- Serialiser:
  - Two states: IDLE and SEND.
  - IDLE -> SEND when the FIFO is non-empty.
  - SEND emits words k=0..NUM_PE/4-1 of the head entry.
  - After the last word is accepted, the entry is popped; the block stays in SEND if another entry exists, else returns to IDLE.
  - No idle bubble between pixels.
- Handshake:
  - A word is transferred on any cycle with wr_en=1 and wr_ready=1.
  - While wr_ready=0, wr_en, wr_addr and wr_data hold stable.
  - wr_en is never deasserted without a transfer, except on start or reset.
- Address: wr_addr = BASE_ADDR + pix_cnt*(NUM_PE/4) + k, where pix_cnt counts written pixels.
- Latency: a capture into an empty FIFO gives wr_en=1 on the next cycle. With wr_ready tied high, one pixel completes in NUM_PE/4 cycles (4 by default).
- FIFO full:
  - A capture while full is dropped and sets overflow.
  - Exception: if the head's last word is accepted in that same cycle, the capture is accepted (pop and push together).
- Empty: wr_en=0; busy=0 once no word is pending.
- done:
  - Set on the cycle after the final word of pixel NUM_PIXELS-1 is accepted; stays high until start.
  - Captures while done=1 are ignored, with no flag set.
- start:
  - Has priority over capture and transfer in the same cycle.
  - Mid-operation start flushes the FIFO, drops any pending word (wr_en=0 next cycle), and zeros the counters, done, overflow and valid_err.
- Counter width: the pixel counter is sized for NUM_PIXELS. The address is truncated to ADDR_W with no wrap check.

Optional Feature:
- OFM_RELU_EN defined:
  - Each captured byte is treated as signed and clamped to 0x00 if bit 7 is set (ReLU), before entering the FIFO.
  - Adds no latency.
- Undefined: bytes are stored unmodified.

Test Plan:
- Reset, then start; one capture with ofm_in bytes ch n = n (0x00..0x0F), wr_ready=1 -> 4 writes on consecutive cycles:
  - addr 0 = 0x00010203
  - addr 1 = 0x04050607
  - addr 2 = 0x08090A0B
  - addr 3 = 0x0C0D0E0F
  - then busy=0.
- wr_ready=0 for 5 cycles mid-pixel -> wr_en, addr and data held constant; no duplicated or lost word once ready returns.
- wr_ready=0 with 5 back-to-back captures (FIFO_DEPTH=4) -> 5th dropped, overflow=1, exactly 16 words written after release. Also check the pop+push-in-same-cycle case: with full FIFO, capture coincides with the last word of the head pixel -> capture accepted, no overflow.
- NUM_PIXELS=3 run with 3 captures -> done rises one cycle after the word at addr 11 is accepted; a 4th capture is ignored; start clears done.
- valid=16'h7FFF pulse -> no FIFO push, valid_err=1. Separately, start asserted mid-SEND -> wr_en=0 next cycle and the next pixel writes to BASE_ADDR.
- OFM_RELU_EN builds: byte 0x85 captured -> written as 0x00; byte 0x7F unchanged. Without the macro, 0x85 is written as 0x85.
